// File: rtl/mux_scan_if.sv
// -----------------------------------------------------------------------------
// mux_scan_if
//   Bundles the channel data, select control and status signals of mux_scan.
//   master : the side that supplies channel data and select control
//            (data sources / control logic, or a testbench).
//   slave  : the mux_scan block itself.
//
//   din        CH*W  channel i at din[i*W +: W]
//   mode       1     0 = manual, 1 = scan
//   hold       1     freeze scan stepping (scan mode only)
//   sel_in     SELW  channel to load
//   sel_load   1     load sel_in into the select register
//   sel        SELW  current select register
//   sel_onehot CH    one-hot decode of sel
//   dout       W     registered selected data
//   dout_ch    SELW  channel number that dout currently holds
//   dout_valid 1     dout holds a sampled value
//   wrap       1     one-cycle pulse when the scan steps CH-1 -> 0
//   sel_err    1     one-cycle pulse on a load with sel_in >= CH
// -----------------------------------------------------------------------------
interface mux_scan_if #(
  parameter int CH   = 4,
  parameter int W    = 8,
  parameter int SELW = 2
);
  logic [CH*W-1:0] din;
  logic            mode;
  logic            hold;
  logic [SELW-1:0] sel_in;
  logic            sel_load;

  logic [SELW-1:0] sel;
  logic [CH-1:0]   sel_onehot;
  logic [W-1:0]    dout;
  logic [SELW-1:0] dout_ch;
  logic            dout_valid;
  logic            wrap;
  logic            sel_err;

  modport master (
    output din, mode, hold, sel_in, sel_load,
    input  sel, sel_onehot, dout, dout_ch, dout_valid, wrap, sel_err
  );

  modport slave (
    input  din, mode, hold, sel_in, sel_load,
    output sel, sel_onehot, dout, dout_ch, dout_valid, wrap, sel_err
  );
endinterface

// File: rtl/mux_scan.sv
// -----------------------------------------------------------------------------
// mux_scan
//   CH-channel, W-bit registered multiplexer with a select sequencer.
//   The select register is either loaded manually (sel_load/sel_in) or, in
//   scan mode, stepped through the channels every DWELL cycles. A three-state
//   FSM (MAN / SCAN / HOLD) controls stepping; the dwell counter clears on
//   every state change and on every accepted load, so a freshly entered or
//   freshly loaded channel always gets a full dwell period.
//
//   Ports
//     clk   rising-edge clock
//     rst_n asynchronous active-low reset
//     bus   mux_scan_if.slave (data in, select control, status out)
//
//   Parameters
//     CH    number of channels (2..16)
//     W     data width per channel (1..32)
//     SELW  select width, CH <= 2**SELW; must match the interface instance
//     DWELL cycles spent on each channel in scan mode (>= 1)
// -----------------------------------------------------------------------------
module mux_scan #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    MAN  = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(CH - 1);
  // One extra bit so the limit is representable even when CH == 2**SELW.
  localparam logic [SELW:0]   CH_LIM   = (SELW + 1)'(CH);

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt;
  logic [SELW-1:0] sel_q;
  logic [W-1:0]    dout_q;
  logic [SELW-1:0] dout_ch_q;
  logic            dout_valid_q;
  logic            wrap_q;
  logic            sel_err_q;

  logic            load_ok;
  logic            state_chg;
  logic            advance;
  logic [W-1:0]    mux_data;
  logic [CH-1:0]   onehot;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MAN;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and step control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load_ok   = 1'b0;
    state_chg = 1'b0;
    advance   = 1'b0;

    unique case (state)
      MAN:     if (bus.mode) state_nxt = bus.hold ? HOLD : SCAN;
      SCAN:    if (!bus.mode)     state_nxt = MAN;
               else if (bus.hold) state_nxt = HOLD;
      HOLD:    if (!bus.mode)     state_nxt = MAN;
               else if (!bus.hold) state_nxt = SCAN;
      default: state_nxt = MAN;
    endcase

    load_ok   = bus.sel_load && ({1'b0, bus.sel_in} < CH_LIM);
    state_chg = (state_nxt != state);
    // A step only happens while staying in SCAN; an accepted load wins.
    advance   = (state == SCAN) && !state_chg && !load_ok && (cnt == CNT_LAST);
  end

  // ---------------------------------------------------------------------------
  // Dwell counter and select register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sel_q     <= '0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      if (state_chg || load_ok)  cnt <= '0;
      else if (state == SCAN)    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

      if (load_ok)       sel_q <= bus.sel_in;
      else if (advance)  sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

      wrap_q    <= advance && (sel_q == SEL_LAST);
      sel_err_q <= bus.sel_load && !load_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel selection and one-hot decode (loops avoid out-of-range indexing
  // when CH < 2**SELW)
  // ---------------------------------------------------------------------------
  always_comb begin
    mux_data = '0;
    onehot   = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel_q == SELW'(i)) begin
        mux_data  = bus.din[i*W +: W];
        onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output datapath: one cycle behind the select register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= mux_data;
      dout_ch_q    <= sel_q;
      dout_valid_q <= 1'b1;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_onehot = onehot;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.sel_err    = sel_err_q;

endmodule

// File: tb/tb_mux_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_scan
//   Directed bench for mux_scan. The main instance uses CH=4, W=8, DWELL=4
//   with SELW=3 so an out-of-range select (sel_in=5) can be presented. A
//   second instance (CH=3, DWELL=1) covers single-cycle dwell and a channel
//   count that is not a power of two.
// -----------------------------------------------------------------------------
module tb_mux_scan;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  mux_scan_if #(.CH(4), .W(8), .SELW(3)) bus ();
  mux_scan_if #(.CH(3), .W(8), .SELW(2)) bus1 ();

  mux_scan #(.CH(4), .W(8), .SELW(3), .DWELL(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_scan #(.CH(3), .W(8), .SELW(2), .DWELL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.din       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.mode      = 1'b0;
    bus.hold      = 1'b0;
    bus.sel_in    = '0;
    bus.sel_load  = 1'b0;
    bus1.din      = {8'h33, 8'h22, 8'h11};
    bus1.mode     = 1'b0;
    bus1.hold     = 1'b0;
    bus1.sel_in   = '0;
    bus1.sel_load = 1'b0;
    #3;
    checks++;
    if (bus.sel !== 3'd0 || bus.sel_onehot !== 4'b0001 || bus.dout !== 8'h00 ||
        bus.dout_ch !== 3'd0 || bus.dout_valid !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sel=%0d onehot=%b dout=%h ch=%0d valid=%b wrap=%b err=%b expected 0 0001 00 0 0 0 0",
               bus.sel, bus.sel_onehot, bus.dout, bus.dout_ch, bus.dout_valid, bus.wrap, bus.sel_err);
    end
    step(2);
    checks++;
    if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: dout=%h valid=%b expected 00 0", bus.dout, bus.dout_valid);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (bus.dout !== 8'hA0 || bus.dout_ch !== 3'd0 || bus.dout_valid !== 1'b1 || bus.sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: dout=%h ch=%0d valid=%b sel=%0d expected a0 0 1 0",
               bus.dout, bus.dout_ch, bus.dout_valid, bus.sel);
    end
  endtask

  task automatic test_manual;
    bus.sel_load = 1'b1;
    bus.sel_in   = 3'd2;
    bus.hold     = 1'b1;  // ignored in manual mode
    step(1);
    bus.sel_load = 1'b0;
    checks++;
    if (bus.sel !== 3'd2 || bus.sel_onehot !== 4'b0100 || bus.dout !== 8'hA0) begin
      errors++;
      $display("FAIL manual_load: sel=%0d onehot=%b dout=%h expected 2 0100 a0",
               bus.sel, bus.sel_onehot, bus.dout);
    end
    step(1);
    checks++;
    if (bus.dout !== 8'hC2 || bus.dout_ch !== 3'd2) begin
      errors++;
      $display("FAIL manual_dout: dout=%h ch=%0d expected c2 2", bus.dout, bus.dout_ch);
    end
    bus.din[23:16] = 8'h5C;
    step(1);
    checks++;
    if (bus.dout !== 8'h5C) begin
      errors++;
      $display("FAIL din_latency: dout=%h expected 5c", bus.dout);
    end
    bus.din[23:16] = 8'hC2;
    bus.hold       = 1'b0;
    step(1);
  endtask

  task automatic test_scan_wrap;
    logic [2:0] exp_sel;
    logic       exp_wrap;
    bus.sel_load = 1'b1;
    bus.sel_in   = 3'd3;
    step(1);
    bus.sel_load = 1'b0;
    bus.mode     = 1'b1;
    step(1);  // entry into SCAN
    step(3);
    checks++;
    if (bus.sel !== 3'd3 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL scan_pre_wrap: sel=%0d wrap=%b expected 3 0", bus.sel, bus.wrap);
    end
    step(1);
    checks++;
    if (bus.sel !== 3'd0 || bus.wrap !== 1'b1 || bus.sel_onehot !== 4'b0001) begin
      errors++;
      $display("FAIL scan_wrap: sel=%0d wrap=%b onehot=%b expected 0 1 0001",
               bus.sel, bus.wrap, bus.sel_onehot);
    end
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp_sel  = 3'((k / 4) % 4);
      exp_wrap = (k == 16);
      checks++;
      if (bus.sel !== exp_sel || bus.wrap !== exp_wrap) begin
        errors++;
        $display("FAIL scan_seq k=%0d: sel=%0d wrap=%b expected %0d %b",
                 k, bus.sel, bus.wrap, exp_sel, exp_wrap);
      end
    end
  endtask

  task automatic test_hold;
    step(2);  // dwell counter now at 2, sel=0
    bus.hold = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      checks++;
      if (bus.sel !== 3'd0 || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_freeze k=%0d: sel=%0d wrap=%b expected 0 0", k, bus.sel, bus.wrap);
      end
    end
    bus.hold = 1'b0;
    step(3);
    checks++;
    if (bus.sel !== 3'd0) begin
      errors++;
      $display("FAIL hold_resume_early: sel=%0d expected 0", bus.sel);
    end
    step(1);
    checks++;
    if (bus.sel !== 3'd0) begin
      errors++;
      $display("FAIL hold_resume_3: sel=%0d expected 0", bus.sel);
    end
    step(1);
    checks++;
    if (bus.sel !== 3'd1 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL hold_resume_adv: sel=%0d wrap=%b expected 1 0", bus.sel, bus.wrap);
    end
  endtask

  task automatic test_load_collision;
    step(11);  // sel=3, dwell counter at its last value
    checks++;
    if (bus.sel !== 3'd3) begin
      errors++;
      $display("FAIL collide_setup: sel=%0d expected 3", bus.sel);
    end
    bus.sel_load = 1'b1;
    bus.sel_in   = 3'd1;
    step(1);
    bus.sel_load = 1'b0;
    checks++;
    if (bus.sel !== 3'd1 || bus.wrap !== 1'b0 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL collide_load: sel=%0d wrap=%b err=%b expected 1 0 0", bus.sel, bus.wrap, bus.sel_err);
    end
    step(3);
    checks++;
    if (bus.sel !== 3'd1) begin
      errors++;
      $display("FAIL collide_dwell: sel=%0d expected 1", bus.sel);
    end
    step(1);
    checks++;
    if (bus.sel !== 3'd2 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL collide_next_adv: sel=%0d wrap=%b expected 2 0", bus.sel, bus.wrap);
    end
  endtask

  task automatic test_sel_err;
    bus.mode = 1'b0;
    step(1);
    checks++;
    if (bus.sel !== 3'd2) begin
      errors++;
      $display("FAIL scan_to_man: sel=%0d expected 2", bus.sel);
    end
    bus.sel_load = 1'b1;
    bus.sel_in   = 3'd5;
    step(1);
    checks++;
    if (bus.sel !== 3'd2 || bus.sel_err !== 1'b1) begin
      errors++;
      $display("FAIL sel_err_5: sel=%0d err=%b expected 2 1", bus.sel, bus.sel_err);
    end
    bus.sel_in = 3'd3;
    step(1);
    checks++;
    if (bus.sel !== 3'd3 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_ok_3: sel=%0d err=%b expected 3 0", bus.sel, bus.sel_err);
    end
    bus.sel_in = 3'd4;
    step(1);
    checks++;
    if (bus.sel !== 3'd3 || bus.sel_err !== 1'b1) begin
      errors++;
      $display("FAIL sel_err_4: sel=%0d err=%b expected 3 1", bus.sel, bus.sel_err);
    end
    bus.sel_load = 1'b0;
    step(1);
    checks++;
    if (bus.sel_err !== 1'b0 || bus.dout !== 8'hD3) begin
      errors++;
      $display("FAIL sel_err_clear: err=%b dout=%h expected 0 d3", bus.sel_err, bus.dout);
    end
  endtask

  task automatic test_async_reset;
    bus.mode = 1'b1;
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sel !== 3'd0 || bus.sel_onehot !== 4'b0001 || bus.dout !== 8'h00 ||
        bus.dout_ch !== 3'd0 || bus.dout_valid !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sel=%0d onehot=%b dout=%h ch=%0d valid=%b wrap=%b err=%b expected 0 0001 00 0 0 0 0",
               bus.sel, bus.sel_onehot, bus.dout, bus.dout_ch, bus.dout_valid, bus.wrap, bus.sel_err);
    end
    #1;
    rst_n = 1'b1;
    step(1);
    checks++;
    if (bus.sel !== 3'd0 || bus.dout !== 8'hA0 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: sel=%0d dout=%h valid=%b expected 0 a0 1", bus.sel, bus.dout, bus.dout_valid);
    end
    step(3);
    checks++;
    if (bus.sel !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_dwell: sel=%0d expected 0", bus.sel);
    end
    step(1);
    checks++;
    if (bus.sel !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_adv: sel=%0d expected 1", bus.sel);
    end
    bus.mode = 1'b0;
    step(1);
  endtask

  task automatic test_dwell1;
    logic [7:0] chan [3];
    logic [1:0] exp_sel;
    logic       exp_wrap;
    chan[0] = 8'h11;
    chan[1] = 8'h22;
    chan[2] = 8'h33;
    bus1.mode = 1'b1;
    step(1);  // entry into SCAN
    checks++;
    if (bus1.sel !== 2'd0 || bus1.sel_onehot !== 3'b001) begin
      errors++;
      $display("FAIL dwell1_entry: sel=%0d onehot=%b expected 0 001", bus1.sel, bus1.sel_onehot);
    end
    for (int k = 1; k <= 6; k++) begin
      step(1);
      exp_sel  = 2'(k % 3);
      exp_wrap = ((k % 3) == 0);
      checks++;
      if (bus1.sel !== exp_sel || bus1.wrap !== exp_wrap || bus1.dout !== chan[(k - 1) % 3]) begin
        errors++;
        $display("FAIL dwell1_seq k=%0d: sel=%0d wrap=%b dout=%h expected %0d %b %h",
                 k, bus1.sel, bus1.wrap, bus1.dout, exp_sel, exp_wrap, chan[(k - 1) % 3]);
      end
    end
    bus1.mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_hold();
    test_load_collision();
    test_sel_err();
    test_async_reset();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
